// File: rtl/uart_pkg.sv
// uart_pkg -- shared types and helpers for the UART core.
//   uart_state_t : FSM state encoding shared by the TX and RX machines
//   frame_bits() : total bits on the line per frame (start + data + parity + stop)
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } uart_state_t;

    function automatic int frame_bits(input int data_width, input int stop_bits,
                                      input int parity);
        return 1 + data_width + ((parity != 0) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// uart_tick_gen -- oversampling tick generator, one instance per direction.
//   clk, rst     : clock, asynchronous active-high reset
//   restart      : reload div into the period register and zero both counters
//   div          : tick period minus one, in clk cycles
//   tick         : one-cycle strobe every div+1 cycles
//   bit_end      : strobe on the last tick of an OVERSAMPLE-tick bit period
//   samp_early/samp_mid/samp_late : strobes on ticks OVERSAMPLE/2-1, /2, /2+1
module uart_tick_gen #(
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 restart,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick,
    output logic                 bit_end,
    output logic                 samp_early,
    output logic                 samp_mid,
    output logic                 samp_late
);

    localparam int IW = $clog2(OVERSAMPLE);

    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] cnt;
    logic [IW-1:0]        idx;

    assign tick       = (cnt == div_q);
    assign bit_end    = tick && (idx == IW'(OVERSAMPLE - 1));
    assign samp_early = tick && (idx == IW'(OVERSAMPLE / 2 - 1));
    assign samp_mid   = tick && (idx == IW'(OVERSAMPLE / 2));
    assign samp_late  = tick && (idx == IW'(OVERSAMPLE / 2 + 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            cnt   <= '0;
            idx   <= '0;
        end else if (restart) begin
            // The period is latched here so a div change mid-frame is ignored.
            div_q <= div;
            cnt   <= '0;
            idx   <= '0;
        end else if (tick) begin
            cnt <= '0;
            // Explicit wrap: OVERSAMPLE need not be a power of two.
            idx <= bit_end ? '0 : idx + IW'(1);
        end else begin
            cnt <= cnt + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_core.sv
// uart_core -- single-clock UART transmitter and receiver.
//   clk, rst   : clock, asynchronous active-high reset
//   div        : tick period minus one; bit period = OVERSAMPLE*(div+1) cycles
//   txd, txv   : byte to send and send request
//   rdy        : transmitter idle and able to accept
//   tx         : serial output (idle high); tx_active high for the whole frame
//   rx         : asynchronous serial input
//   rxd, rxv   : received data and its one-cycle strobe
//   perr, ferr : parity / framing error of the frame strobed by rxv
//   brk        : break detected (only with UART_BREAK_DET_EN defined, else 0)
// Handshake: a transfer is taken on a rising edge where txv && rdy; txd and
// div are captured on that edge. txv while rdy is low is ignored, and rdy is
// high again the cycle after the last stop bit ends so back-to-back frames
// need no extra idle time.
module uart_core
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY     = 0,
    parameter int EVEN       = 0,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIV_WIDTH-1:0]  div,
    input  logic                  rx,
    output logic                  tx,
    input  logic [DATA_WIDTH-1:0] txd,
    input  logic                  txv,
    output logic                  rdy,
    output logic                  tx_active,
    output logic [DATA_WIDTH-1:0] rxd,
    output logic                  rxv,
    output logic                  perr,
    output logic                  ferr,
    output logic                  brk
);

    localparam int FRAME_BITS = frame_bits(DATA_WIDTH, STOP_BITS, PARITY);

    // ---------------- transmitter ----------------
    uart_state_t           tx_state;
    logic [DATA_WIDTH-1:0] tx_sh;
    logic                  tx_par;
    logic [3:0]            tx_idx;     // index of the bit currently on the line
    logic                  tx_accept;
    logic                  tx_bit_end;
    logic                  tx_unused_tick, tx_unused_early, tx_unused_mid, tx_unused_late;

    assign tx_accept = txv && rdy;

    uart_tick_gen #(.OVERSAMPLE(OVERSAMPLE), .DIV_WIDTH(DIV_WIDTH)) u_tx_tick (
        .clk(clk), .rst(rst), .restart(tx_accept), .div(div),
        .tick(tx_unused_tick), .bit_end(tx_bit_end),
        .samp_early(tx_unused_early), .samp_mid(tx_unused_mid), .samp_late(tx_unused_late)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state  <= ST_IDLE;
            tx        <= 1'b1;
            rdy       <= 1'b0;
            tx_active <= 1'b0;
            tx_sh     <= '0;
            tx_par    <= 1'b0;
            tx_idx    <= '0;
        end else begin
            case (tx_state)
                ST_IDLE: begin
                    tx <= 1'b1;
                    if (tx_accept) begin
                        tx_state  <= ST_START;
                        tx        <= 1'b0;
                        rdy       <= 1'b0;
                        tx_active <= 1'b1;
                        tx_sh     <= txd;
                        tx_par    <= (EVEN != 0) ? ^txd : ~^txd;
                        tx_idx    <= '0;
                    end else begin
                        rdy <= 1'b1;
                    end
                end
                ST_START: if (tx_bit_end) begin
                    tx_state <= ST_DATA;
                    tx       <= tx_sh[0];
                    tx_sh    <= tx_sh >> 1;
                    tx_idx   <= tx_idx + 4'd1;
                end
                ST_DATA: if (tx_bit_end) begin
                    tx_idx <= tx_idx + 4'd1;
                    if (tx_idx == 4'(DATA_WIDTH)) begin
                        if (PARITY != 0) begin
                            tx_state <= ST_PAR;
                            tx       <= tx_par;
                        end else begin
                            tx_state <= ST_STOP;
                            tx       <= 1'b1;
                        end
                    end else begin
                        tx    <= tx_sh[0];
                        tx_sh <= tx_sh >> 1;
                    end
                end
                ST_PAR: if (tx_bit_end) begin
                    tx_state <= ST_STOP;
                    tx       <= 1'b1;
                    tx_idx   <= tx_idx + 4'd1;
                end
                ST_STOP: if (tx_bit_end) begin
                    if (tx_idx == 4'(FRAME_BITS - 1)) begin
                        tx_state  <= ST_IDLE;
                        tx_active <= 1'b0;
                        rdy       <= 1'b1;
                    end else begin
                        tx_idx <= tx_idx + 4'd1;
                    end
                end
                default: tx_state <= ST_IDLE;
            endcase
        end
    end

    // ---------------- receiver ----------------
    uart_state_t           rx_state;
    logic                  rx_s1, rx_s2, rx_prev;
    logic [DATA_WIDTH-1:0] rx_sh;
    logic [3:0]            rx_cnt;
    logic                  rx_pbit;
    logic                  smp0, smp1;
    logic                  rx_maj, rx_start, rx_par_exp;
    logic                  rx_bit_end, rx_samp_early, rx_samp_mid, rx_samp_late;
    logic                  rx_unused_tick;

    assign rx_start   = (rx_state == ST_IDLE) && rx_prev && !rx_s2;
    // 2-of-3 vote over the early/mid samples and the live late sample.
    assign rx_maj     = (smp0 & smp1) | (smp0 & rx_s2) | (smp1 & rx_s2);
    assign rx_par_exp = (EVEN != 0) ? ^rx_sh : ~^rx_sh;

    uart_tick_gen #(.OVERSAMPLE(OVERSAMPLE), .DIV_WIDTH(DIV_WIDTH)) u_rx_tick (
        .clk(clk), .rst(rst), .restart(rx_start), .div(div),
        .tick(rx_unused_tick), .bit_end(rx_bit_end),
        .samp_early(rx_samp_early), .samp_mid(rx_samp_mid), .samp_late(rx_samp_late)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= ST_IDLE;
            rx_sh    <= '0;
            rx_cnt   <= '0;
            rx_pbit  <= 1'b0;
            smp0     <= 1'b0;
            smp1     <= 1'b0;
            rxd      <= '0;
            rxv      <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            rxv     <= 1'b0;
            if (rx_samp_early) smp0 <= rx_s2;
            if (rx_samp_mid)   smp1 <= rx_s2;
            case (rx_state)
                ST_IDLE: if (rx_start) begin
                    rx_state <= ST_START;
                    rx_cnt   <= '0;
                end
                ST_START: begin
                    // Line back high at mid start bit: treat as a glitch.
                    if (rx_samp_mid && rx_s2)  rx_state <= ST_IDLE;
                    else if (rx_bit_end)       rx_state <= ST_DATA;
                end
                ST_DATA: begin
                    if (rx_samp_late) rx_sh <= {rx_maj, rx_sh[DATA_WIDTH-1:1]};
                    if (rx_bit_end) begin
                        rx_cnt <= rx_cnt + 4'd1;
                        if (rx_cnt == 4'(DATA_WIDTH - 1)) begin
                            if (PARITY != 0) rx_state <= ST_PAR;
                            else             rx_state <= ST_STOP;
                        end
                    end
                end
                ST_PAR: begin
                    if (rx_samp_late) rx_pbit  <= rx_maj;
                    if (rx_bit_end)   rx_state <= ST_STOP;
                end
                ST_STOP: if (rx_samp_late) begin
                    // Only the first stop bit is checked; back to IDLE at once.
                    rxv      <= 1'b1;
                    rxd      <= rx_sh;
                    ferr     <= !rx_maj;
                    perr     <= (PARITY != 0) ? (rx_pbit != rx_par_exp) : 1'b0;
                    rx_state <= ST_IDLE;
                end
                default: rx_state <= ST_IDLE;
            endcase
        end
    end

`ifdef UART_BREAK_DET_EN
    logic rx_all_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            brk         <= 1'b0;
            rx_all_zero <= 1'b1;
        end else begin
            if (rx_start)
                rx_all_zero <= 1'b1;
            else if (rx_samp_late && rx_maj &&
                     (rx_state == ST_DATA || rx_state == ST_PAR))
                rx_all_zero <= 1'b0;
            if (rx_state == ST_STOP && rx_samp_late && rx_all_zero && !rx_maj)
                brk <= 1'b1;
            else if (rx_s2)
                brk <= 1'b0;
        end
    end
`else
    assign brk = 1'b0;
`endif

endmodule

// File: tb/tb_uart_core.sv
module tb_uart_core;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [15:0] div;
    logic [7:0]  txd_a, txd_b, rxd_a, rxd_b;
    logic        txv_a, txv_b;
    logic        tx_a, rdy_a, act_a, rxv_a, perr_a, ferr_a, brk_a;
    logic        tx_b, rdy_b, act_b, rxv_b, perr_b, ferr_b, brk_b;
    logic        loop_a, loop_b, drv_a, drv_b;
    logic        rx_a, rx_b;

    assign rx_a = loop_a ? tx_a : drv_a;
    assign rx_b = loop_b ? tx_b : drv_b;

`ifdef UART_BREAK_DET_EN
    localparam logic BRK_EXP = 1'b1;
`else
    localparam logic BRK_EXP = 1'b0;
`endif

    // 8N1 instance
    uart_core #(.DATA_WIDTH(8), .STOP_BITS(1), .PARITY(0), .EVEN(0),
                .OVERSAMPLE(16), .DIV_WIDTH(16)) u_dut_a (
        .clk(clk), .rst(rst), .div(div), .rx(rx_a), .tx(tx_a),
        .txd(txd_a), .txv(txv_a), .rdy(rdy_a), .tx_active(act_a),
        .rxd(rxd_a), .rxv(rxv_a), .perr(perr_a), .ferr(ferr_a), .brk(brk_a)
    );

    // 8O1 instance
    uart_core #(.DATA_WIDTH(8), .STOP_BITS(1), .PARITY(1), .EVEN(0),
                .OVERSAMPLE(16), .DIV_WIDTH(16)) u_dut_b (
        .clk(clk), .rst(rst), .div(div), .rx(rx_b), .tx(tx_b),
        .txd(txd_b), .txv(txv_b), .rdy(rdy_b), .tx_active(act_b),
        .rxd(rxd_b), .rxv(rxv_b), .perr(perr_b), .ferr(ferr_b), .brk(brk_b)
    );

    // ---------------- monitors ----------------
    int act_cnt_a = 0, rxv_cnt_a = 0, act_cnt_b = 0, rxv_cnt_b = 0;
    logic [7:0] rx_log_a[$];

    always @(negedge clk) begin
        if (act_a) act_cnt_a++;
        if (act_b) act_cnt_b++;
        if (rxv_b) rxv_cnt_b++;
        if (rxv_a) begin
            rxv_cnt_a++;
            rx_log_a.push_back(rxd_a);
        end
    end

    // ---------------- scoreboard ----------------
    int tests_run = 0;
    int tests_failed = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_rx(input int sel, input logic v);
        if (sel == 0) drv_a = v;
        else          drv_b = v;
    endtask

    // Bit-bang one frame at div=1 (32 cycles per bit), then idle high.
    task automatic send_rx(input int sel, input logic [7:0] data, input logic has_par,
                           input logic par, input logic stop);
        logic [10:0] bits;
        int n;
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = data;
        if (has_par) begin
            bits[9]  = par;
            bits[10] = stop;
            n = 11;
        end else begin
            bits[9] = stop;
            n = 10;
        end
        for (int i = 0; i < n; i++) begin
            set_rx(sel, bits[i]);
            repeat (32) @(negedge clk);
        end
        set_rx(sel, 1'b1);
        repeat (40) @(negedge clk);
    endtask

    task automatic wait_idle(input int sel, input string tag);
        int k;
        k = 0;
        while (((sel == 0) ? act_a : act_b) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check(tag, {31'd0, (sel == 0) ? act_a : act_b}, 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    int base_act, base_rxv, base_log, k;
    logic [9:0] frame;

    initial begin
        rst = 1'b1; div = 16'd1;
        txd_a = '0; txd_b = '0; txv_a = 1'b0; txv_b = 1'b0;
        loop_a = 1'b1; loop_b = 1'b1; drv_a = 1'b1; drv_b = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_tx",   {31'd0, tx_a},   32'd1);
        check("rst_rdy",  {31'd0, rdy_a},  32'd0);
        check("rst_act",  {31'd0, act_a},  32'd0);
        check("rst_rxv",  {31'd0, rxv_a},  32'd0);
        check("rst_rxd",  {24'd0, rxd_a},  32'd0);
        check("rst_perr", {31'd0, perr_a}, 32'd0);
        check("rst_ferr", {31'd0, ferr_a}, 32'd0);
        check("rst_brk",  {31'd0, brk_a},  32'd0);

        rst = 1'b0;
        check("rdy_before_edge", {31'd0, rdy_a}, 32'd0);
        @(negedge clk);
        check("rdy_after_release", {31'd0, rdy_a}, 32'd1);

        // Loopback 8N1, 0xA5
        base_act = act_cnt_a; base_rxv = rxv_cnt_a;
        txd_a = 8'hA5; txv_a = 1'b1;
        @(negedge clk);
        txv_a = 1'b0;
        check("a5_start_low", {31'd0, tx_a},  32'd0);
        check("a5_rdy_low",   {31'd0, rdy_a}, 32'd0);
        check("a5_active",    {31'd0, act_a}, 32'd1);
        frame = {1'b1, 8'hA5, 1'b0};
        repeat (15) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("a5_bit%0d", i), {31'd0, tx_a}, {31'd0, frame[i]});
            if (i < 9) repeat (32) @(negedge clk);
        end
        wait_idle(0, "a5_idle_timeout");
        check("a5_active_cycles", act_cnt_a - base_act, 32'd320);
        check("a5_rxv_count", rxv_cnt_a - base_rxv, 32'd1);
        check("a5_rxd",  {24'd0, rxd_a},  32'hA5);
        check("a5_perr", {31'd0, perr_a}, 32'd0);
        check("a5_ferr", {31'd0, ferr_a}, 32'd0);
        check("a5_rdy",  {31'd0, rdy_a},  32'd1);

        // Back-to-back with txv held high
        base_act = act_cnt_a; base_rxv = rxv_cnt_a; base_log = rx_log_a.size();
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        txd_a = 8'h11; txv_a = 1'b1;
        @(negedge clk);
        txd_a = 8'h22;
        k = 0;
        while (!rdy_a && k < 2000) begin @(negedge clk); k++; end
        check("b2b_rdy_timeout", {31'd0, rdy_a}, 32'd1);
        check("b2b_gap_active",  {31'd0, act_a}, 32'd0);
        check("b2b_gap_tx",      {31'd0, tx_a},  32'd1);
        @(negedge clk);
        txv_a = 1'b0;
        check("b2b_second_start", {31'd0, tx_a},  32'd0);
        check("b2b_second_act",   {31'd0, act_a}, 32'd1);
        wait_idle(0, "b2b_idle_timeout");
        check("b2b_active_cycles", act_cnt_a - base_act, 32'd640);
        check("b2b_rxv_count", rxv_cnt_a - base_rxv, 32'd2);
        for (int i = 0; i < 2; i++) begin
            if (rx_log_a.size() > base_log + i)
                check($sformatf("b2b_rxd%0d", i), {24'd0, rx_log_a[base_log + i]},
                      {24'd0, exp_q[0]});
            else
                check($sformatf("b2b_rxd%0d_missing", i), rx_log_a.size(), base_log + i + 1);
            void'(exp_q.pop_front());
        end

        // Framing error: stop bit forced low
        loop_a = 1'b0; drv_a = 1'b1;
        repeat (5) @(negedge clk);
        base_rxv = rxv_cnt_a;
        send_rx(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        check("ferr_rxv_count", rxv_cnt_a - base_rxv, 32'd1);
        check("ferr_rxd",  {24'd0, rxd_a},  32'h3C);
        check("ferr_flag", {31'd0, ferr_a}, 32'd1);
        check("ferr_perr", {31'd0, perr_a}, 32'd0);
        check("ferr_brk",  {31'd0, brk_a},  32'd0);

        // Glitch reject: 4 cycles low, then a normal frame
        base_rxv = rxv_cnt_a;
        drv_a = 1'b0;
        repeat (4) @(negedge clk);
        drv_a = 1'b1;
        repeat (100) @(negedge clk);
        check("glitch_no_rxv", rxv_cnt_a - base_rxv, 32'd0);
        send_rx(0, 8'h5A, 1'b0, 1'b0, 1'b1);
        check("glitch_then_rxv", rxv_cnt_a - base_rxv, 32'd1);
        check("glitch_then_rxd", {24'd0, rxd_a}, 32'h5A);
        check("glitch_then_ferr", {31'd0, ferr_a}, 32'd0);

        // Odd parity, 0xFF, loopback on instance B
        base_act = act_cnt_b; base_rxv = rxv_cnt_b;
        txd_b = 8'hFF; txv_b = 1'b1;
        @(negedge clk);
        txv_b = 1'b0;
        repeat (15 + 32 * 9) @(negedge clk);
        check("par_bit_on_tx", {31'd0, tx_b}, 32'd1);
        wait_idle(1, "par_idle_timeout");
        check("par_active_cycles", act_cnt_b - base_act, 32'd352);
        check("par_rxv_count", rxv_cnt_b - base_rxv, 32'd1);
        check("par_rxd",  {24'd0, rxd_b},  32'hFF);
        check("par_perr", {31'd0, perr_b}, 32'd0);
        check("par_ferr", {31'd0, ferr_b}, 32'd0);
        loop_b = 1'b0;
        send_rx(1, 8'hFF, 1'b1, 1'b0, 1'b1);
        check("par_forced_perr", {31'd0, perr_b}, 32'd1);
        check("par_forced_rxd",  {24'd0, rxd_b},  32'hFF);
        send_rx(1, 8'h00, 1'b1, 1'b1, 1'b1);
        check("par_zero_perr", {31'd0, perr_b}, 32'd0);
        check("par_zero_rxd",  {24'd0, rxd_b},  32'h00);
        check("par_rxv_total", rxv_cnt_b - base_rxv, 32'd3);

        // Reset during the data phase
        loop_a = 1'b1;
        base_rxv = rxv_cnt_a;
        txd_a = 8'h00; txv_a = 1'b1;
        @(negedge clk);
        txv_a = 1'b0;
        repeat (100) @(negedge clk);
        check("mid_data_low", {31'd0, tx_a}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_tx",  {31'd0, tx_a},  32'd1);
        check("mid_rst_rdy", {31'd0, rdy_a}, 32'd0);
        check("mid_rst_act", {31'd0, act_a}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("mid_release_rdy", {31'd0, rdy_a}, 32'd1);
        check("mid_release_tx",  {31'd0, tx_a},  32'd1);
        repeat (400) @(negedge clk);
        check("mid_rst_no_rxv", rxv_cnt_a - base_rxv, 32'd0);

        // Break: line low for 12 bit periods
        loop_a = 1'b0; drv_a = 1'b1;
        repeat (5) @(negedge clk);
        base_rxv = rxv_cnt_a;
        drv_a = 1'b0;
        repeat (384) @(negedge clk);
        check("brk_rxv_count", rxv_cnt_a - base_rxv, 32'd1);
        check("brk_rxd",  {24'd0, rxd_a},  32'h00);
        check("brk_ferr", {31'd0, ferr_a}, 32'd1);
        check("brk_flag", {31'd0, brk_a},  {31'd0, BRK_EXP});
        drv_a = 1'b1;
        repeat (5) @(negedge clk);
        check("brk_cleared", {31'd0, brk_a}, 32'd0);
        check("brk_no_extra_rxv", rxv_cnt_a - base_rxv, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
